m68k_dtack_ctrl: RTL and testbench
==================================

Name: m68k_dtack_ctrl

Overview:
- Bus-cycle sequencer for the 68000 core. Watches nAS, address and strobes, decodes the NeoGeo memory region, and counts wait states or handshakes with the SDRAM controller.
- Drives nDTACK back to the CPU and releases it when the cycle ends.
- Sits between the CPU wrapper and the memory/IO fabric, replacing the fixed-DTACK glue.

Parameters:
- WS_WRAM, 0: wait states (68K P-enables) for work RAM 0x100000-0x1FFFFF.
- WS_IO, 1: wait states for I/O 0x300000-0x3FFFFF.
- WS_PAL, 0: wait states for palette 0x400000-0x7FFFFF.
- WS_CARD, 2: wait states for memory card 0x800000-0xBFFFFF.
- WS_BRAM, 0: wait states for backup RAM 0xD00000-0xDFFFFF.
- WS_UNMAP, 3: wait states for every other unmapped address.
- TIMEOUT_CYC, 256: P-enables before a bus error is raised (DTACK_TIMEOUT_EN only).

Ports:
- CLK_48M in 1: system clock.
- nRESET in 1: asynchronous, active-low reset.
- CLK_EN_68K_P in 1: 68K phi1 clock enable.
- M68K_ADDR in 23: CPU address [23:1].
- nAS in 1: address strobe, active low.
- nUDS in 1: upper data strobe.
- nLDS in 1: lower data strobe.
- M68K_RW in 1: 1 = read.
- SDR_REQ out 1: one-clock request pulse to the SDRAM controller.
- SDR_RD out 1: read/write for the current request, valid while SDR_REQ is high.
- SDR_ACK in 1: SDRAM controller done pulse (one clock).
- nDTACK out 1: data acknowledge to the CPU, active low.
- nBERR out 1: bus error to the CPU, active low.
- BUSY out 1: high while a cycle is in flight (IDLE excluded).

Behaviour:
- Reset: asynchronous and active-low. All flops are cleared asynchronously.
- Reset values: state = IDLE, nDTACK = 1, nBERR = 1, SDR_REQ = 0, SDR_RD = 1, BUSY = 0.
- A reset mid-cycle aborts immediately; no DTACK is produced for the aborted cycle.
- Start of cycle: IDLE leaves only on CLK_EN_68K_P with nAS = 0 and (nUDS & nLDS) = 0. At that point the region is latched from ADDR[23:20] and RW is latched.
- SDRAM regions: 0x000000-0x0FFFFF, 0x200000-0x2FFFFF and 0xC00000-0xCFFFFF.
  - Next state is SDR_WAIT; SDR_REQ pulses for exactly one CLK_48M; SDR_RD = latched RW.
- Counted regions: next state is WCNT; the 4-bit counter is loaded with the region's WS_*.
  - Counter 0: go to ACK on the same transition (nDTACK low one clock after the start sample).
  - Otherwise the counter decrements on each CLK_EN_68K_P; ACK is entered when it reaches 0.
- Interrupt acknowledge: ADDR[23:4] all ones means an IACK cycle, serviced by VPA. Go to HOLD with nDTACK kept at 1.
- SDR_WAIT: SDR_ACK moves to ACK on the next clock.
  - If SDR_ACK arrives in the same clock as the request pulse, it is accepted.
- ACK: nDTACK = 0; stays until nAS is sampled high on any CLK_48M edge. Then nDTACK = 1 on the next clock and state returns to IDLE.
- HOLD: nDTACK = 1; state returns to IDLE once nAS is high.
- Abort: nAS high while in WCNT goes straight to IDLE with no DTACK.
  - nAS high while in SDR_WAIT goes to DRAIN, which waits for SDR_ACK and then returns to IDLE, so no SDRAM ack is ever orphaned.
  - A new cycle is not accepted while in DRAIN.
- Back-to-back cycles: one idle CLK_48M is guaranteed between nDTACK release and the next start sample.
- Read-modify-write (TAS): nAS stays low across both halves. In ACK, a rising edge on (nUDS & nLDS) re-enters decode on the next CLK_EN_68K_P with nAS low, and nDTACK is released in between.

Optional Feature:
- Macro: DTACK_TIMEOUT_EN.
- When defined:
  - An 9-bit counter clears on each cycle start and increments on CLK_EN_68K_P in SDR_WAIT and WCNT.
  - When it reaches TIMEOUT_CYC: nBERR = 0, nDTACK stays 1, state goes to BERR. An outstanding SDRAM request is drained as in DRAIN.
  - BERR releases nBERR once nAS is high, then returns to IDLE.
- When undefined:
  - nBERR is constant 1 and no timeout logic is synthesized.
  - An SDRAM ack that never arrives stalls the CPU indefinitely.

Test Plan:
- Work RAM read at 0x100000, WS_WRAM = 0 -> nDTACK low 1 CLK_48M after the start sample; high 1 clock after nAS rises; SDR_REQ never asserted.
- I/O write at 0x300000, WS_IO = 1 -> nDTACK low exactly one CLK_EN_68K_P later than the work RAM case.
- P-ROM read at 0x000400, SDR_ACK returned 7 clocks after the request -> single SDR_REQ pulse with SDR_RD = 1; nDTACK low on the clock after SDR_ACK.
- IACK at 0xFFFFFE -> nDTACK stays 1 throughout; BUSY falls when nAS rises.
- nAS raised in SDR_WAIT before SDR_ACK, with a new nAS asserted 2 clocks later -> no DTACK; new cycle is ignored until SDR_ACK arrives, then accepted at the next P-enable.
- DTACK_TIMEOUT_EN with TIMEOUT_CYC = 16 and SDR_ACK withheld -> nBERR low after 16 P-enables, nDTACK stays 1; a late SDR_ACK drains; nRESET low mid-cycle forces nDTACK = 1, nBERR = 1 and BUSY = 0 asynchronously.

Source files
------------

// File: rtl/m68k_dtack_ctrl.sv
// m68k_dtack_ctrl: 68000 bus-cycle sequencer for the NeoGeo map; decodes the region, counts wait
// states or handshakes with the SDRAM controller, and drives nDTACK. Define DTACK_TIMEOUT_EN for the nBERR timeout.
module m68k_dtack_ctrl #(
  parameter int WS_WRAM     = 0,
  parameter int WS_IO       = 1,
  parameter int WS_PAL      = 0,
  parameter int WS_CARD     = 2,
  parameter int WS_BRAM     = 0,
  parameter int WS_UNMAP    = 3,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        CLK_48M,
  input  logic        nRESET,
  input  logic        CLK_EN_68K_P,
  input  logic [23:1] M68K_ADDR,
  input  logic        nAS,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic        M68K_RW,
  output logic        SDR_REQ,
  output logic        SDR_RD,
  input  logic        SDR_ACK,
  output logic        nDTACK,
  output logic        nBERR,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_SDR_WAIT, S_WCNT, S_ACK, S_HOLD, S_DRAIN, S_BERR
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_ws_cnt, w_ws_cnt_nxt;
  logic       r_strb_idle;
  logic       r_sdr_req, w_sdr_req_nxt;
  logic       r_sdr_rd, w_sdr_rd_nxt;
  logic       r_dtack_n, r_busy;
  logic       w_strb_idle, w_strb_rise, w_start, w_iack;
  logic       w_rgn_sdram;
  logic [3:0] w_rgn_ws;
  logic       w_timeout, w_sdr_pend;
  logic       w_unused;

  assign w_strb_idle = nUDS & nLDS;
  assign w_strb_rise = w_strb_idle & ~r_strb_idle;
  assign w_start     = CLK_EN_68K_P & ~nAS & ~w_strb_idle;
  assign w_iack      = &M68K_ADDR[23:4];

  // Region decode on the 1 MB granule; anything not listed uses the unmapped wait count.
  always_comb begin
    w_rgn_sdram = 1'b0;
    w_rgn_ws    = 4'(WS_UNMAP);
    case (M68K_ADDR[23:20])
      4'h0, 4'h2, 4'hC:        w_rgn_sdram = 1'b1;
      4'h1:                    w_rgn_ws    = 4'(WS_WRAM);
      4'h3:                    w_rgn_ws    = 4'(WS_IO);
      4'h4, 4'h5, 4'h6, 4'h7:  w_rgn_ws    = 4'(WS_PAL);
      4'h8, 4'h9, 4'hA, 4'hB:  w_rgn_ws    = 4'(WS_CARD);
      4'hD:                    w_rgn_ws    = 4'(WS_BRAM);
      default: ;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_ws_cnt_nxt  = r_ws_cnt;
    w_sdr_req_nxt = 1'b0;
    w_sdr_rd_nxt  = r_sdr_rd;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_iack) begin
            w_state_nxt = S_HOLD;
          end else if (w_rgn_sdram) begin
            w_state_nxt   = S_SDR_WAIT;
            w_sdr_req_nxt = 1'b1;
            w_sdr_rd_nxt  = M68K_RW;
          end else if (w_rgn_ws == 4'd0) begin
            w_state_nxt = S_ACK;
          end else begin
            w_state_nxt  = S_WCNT;
            w_ws_cnt_nxt = w_rgn_ws;
          end
        end
      end
      S_SDR_WAIT: begin
        // An ack coinciding with an abort is consumed here, so DRAIN never waits for it.
        if (SDR_ACK)        w_state_nxt = nAS ? S_IDLE : S_ACK;
        else if (nAS)       w_state_nxt = S_DRAIN;
        else if (w_timeout) w_state_nxt = S_BERR;
      end
      S_WCNT: begin
        if (nAS) begin
          w_state_nxt = S_IDLE;
        end else if (CLK_EN_68K_P) begin
          w_ws_cnt_nxt = r_ws_cnt - 4'd1;
          if (r_ws_cnt == 4'd1) w_state_nxt = S_ACK;
          else if (w_timeout)   w_state_nxt = S_BERR;
        end
      end
      S_ACK:   if (nAS || w_strb_rise) w_state_nxt = S_IDLE;
      S_HOLD:  if (nAS) w_state_nxt = S_IDLE;
      S_DRAIN: if (SDR_ACK) w_state_nxt = S_IDLE;
      S_BERR:  if (nAS) w_state_nxt = (w_sdr_pend && !SDR_ACK) ? S_DRAIN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the CPU-facing strobes never glitch.
  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
  always_ff @(posedge CLK_48M or negedge nRESET) begin
    if (!nRESET) begin
      r_state     <= S_IDLE;
      r_ws_cnt    <= '0;
      r_strb_idle <= 1'b1;
      r_sdr_req   <= 1'b0;
      r_sdr_rd    <= 1'b1;
      r_dtack_n   <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ws_cnt    <= w_ws_cnt_nxt;
      r_strb_idle <= w_strb_idle;
      r_sdr_req   <= w_sdr_req_nxt;
      r_sdr_rd    <= w_sdr_rd_nxt;
      r_dtack_n   <= (w_state_nxt != S_ACK);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef DTACK_TIMEOUT_EN
  logic [8:0] r_to_cnt;
  logic       r_sdr_pend;
  logic       r_berr_n;

  assign w_timeout  = CLK_EN_68K_P && (r_state == S_SDR_WAIT || r_state == S_WCNT) &&
                      (r_to_cnt == 9'(TIMEOUT_CYC - 1));
  assign w_sdr_pend = r_sdr_pend;
  assign w_unused   = ^M68K_ADDR[3:1];

  always_ff @(posedge CLK_48M or negedge nRESET) begin
    if (!nRESET) begin
      r_to_cnt   <= '0;
      r_sdr_pend <= 1'b0;
      r_berr_n   <= 1'b1;
    end else begin
      if (r_state == S_IDLE)
        r_to_cnt <= '0;
      else if (CLK_EN_68K_P && (r_state == S_SDR_WAIT || r_state == S_WCNT))
        r_to_cnt <= r_to_cnt + 9'd1;
      // Tracks an SDRAM request whose ack is still owed, so a bus error can drain it.
      if (w_sdr_req_nxt)
        r_sdr_pend <= 1'b1;
      else if (SDR_ACK)
        r_sdr_pend <= 1'b0;
      r_berr_n <= (w_state_nxt != S_BERR);
    end
  end

  assign nBERR = r_berr_n;
`else
  assign w_timeout  = 1'b0;
  assign w_sdr_pend = 1'b0;
  assign w_unused   = ^M68K_ADDR[3:1] ^ (TIMEOUT_CYC == 0);
  assign nBERR      = 1'b1;
`endif

  assign SDR_REQ = r_sdr_req;
  assign SDR_RD  = r_sdr_rd;
  assign nDTACK  = r_dtack_n;
  assign BUSY    = r_busy;

endmodule

// File: tb/tb_m68k_dtack_ctrl.sv
// Self-checking bench for m68k_dtack_ctrl: directed test-plan cases plus randomized bus cycles
// checked against a region/latency model. Define DTACK_TIMEOUT_EN to also exercise the timeout.
module tb_m68k_dtack_ctrl;
  localparam int WS_WRAM = 0, WS_IO = 1, WS_PAL = 0, WS_CARD = 2, WS_BRAM = 0, WS_UNMAP = 3;
  localparam int TIMEOUT_CYC = 16;

  logic        CLK_48M;
  logic        nRESET = 1'b0;
  logic        CLK_EN_68K_P = 1'b0;
  logic [23:1] M68K_ADDR = '0;
  logic        nAS = 1'b1, nUDS = 1'b1, nLDS = 1'b1, M68K_RW = 1'b1, SDR_ACK = 1'b0;
  logic        SDR_REQ, SDR_RD, nDTACK, nBERR, BUSY;

  int vectors = 0, miscompares = 0, cyc = 0, req_cnt = 0;

  m68k_dtack_ctrl #(
    .WS_WRAM(WS_WRAM), .WS_IO(WS_IO), .WS_PAL(WS_PAL), .WS_CARD(WS_CARD),
    .WS_BRAM(WS_BRAM), .WS_UNMAP(WS_UNMAP), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK_48M(CLK_48M), .nRESET(nRESET), .CLK_EN_68K_P(CLK_EN_68K_P),
    .M68K_ADDR(M68K_ADDR), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS), .M68K_RW(M68K_RW),
    .SDR_REQ(SDR_REQ), .SDR_RD(SDR_RD), .SDR_ACK(SDR_ACK),
    .nDTACK(nDTACK), .nBERR(nBERR), .BUSY(BUSY)
  );

  initial begin
    CLK_48M = 1'b0;
    forever #5 CLK_48M = ~CLK_48M;
  end

  always @(negedge CLK_48M) if (SDR_REQ === 1'b1) req_cnt++;

  // ---------------- reference model ----------------
  function automatic bit is_iack(input logic [23:0] a);
    return a >= 24'hFFFFF0;
  endfunction

  function automatic bit is_sdram(input logic [23:0] a);
    return (a < 24'h100000) || (a >= 24'h200000 && a < 24'h300000) ||
           (a >= 24'hC00000 && a < 24'hD00000);
  endfunction

  function automatic int exp_ws(input logic [23:0] a);
    if (a >= 24'h100000 && a < 24'h200000) return WS_WRAM;
    if (a >= 24'h300000 && a < 24'h400000) return WS_IO;
    if (a >= 24'h400000 && a < 24'h800000) return WS_PAL;
    if (a >= 24'h800000 && a < 24'hC00000) return WS_CARD;
    if (a >= 24'hD00000 && a < 24'hE00000) return WS_BRAM;
    return WS_UNMAP;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CLK_48M edge; returns 1 ns later with a fresh P-enable value for the next edge.
  task automatic tick();
    @(posedge CLK_48M);
    #1;
    cyc++;
    CLK_EN_68K_P = (cyc % 4 == 3);
  endtask

  // Drives the bus and returns just after the P-enable edge that samples the start.
  task automatic start_cycle(input logic [23:0] a, input logic rw);
    int  sel;
    bit  pe, done;
    sel       = $urandom_range(0, 2);
    M68K_ADDR = a[23:1];
    M68K_RW   = rw;
    nUDS      = (sel == 2);
    nLDS      = (sel == 1);
    nAS       = 1'b0;
    done      = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      pe = CLK_EN_68K_P;
      tick();
      if (pe) done = 1'b1;
    end
  endtask

  task automatic finish_cycle(input string tag);
    int hold;
    bit stayed;
    hold   = $urandom_range(0, 3);
    stayed = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (nDTACK !== 1'b0) stayed = 1'b0;
    end
    check({tag, "_dtack_held"}, stayed, 1);
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    tick();
    check({tag, "_dtack_release"}, nDTACK, 1);
    check({tag, "_busy_release"}, BUSY, 0);
    tick();
  endtask

  task automatic run_cycle(input string tag, input logic [23:0] a, input logic rw, input int d);
    int req0, n, pes;
    bit got, pe, last_pe, low;
    req0 = req_cnt;
    start_cycle(a, rw);
    check({tag, "_busy_start"}, BUSY, 1);
    if (is_iack(a)) begin
      low = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (nDTACK !== 1'b1) low = 1'b1;
        tick();
      end
      check({tag, "_iack_no_dtack"}, low, 0);
      check({tag, "_iack_busy"}, BUSY, 1);
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
      tick();
      check({tag, "_iack_busy_fall"}, BUSY, 0);
      check({tag, "_iack_dtack"}, nDTACK, 1);
      tick();
    end else if (is_sdram(a)) begin
      check({tag, "_sdr_req"}, SDR_REQ, 1);
      check({tag, "_sdr_rd"}, SDR_RD, rw);
      n = 0; got = 1'b0;
      for (int k = 0; k < 64 && !got; k++) begin
        SDR_ACK = (k == d);
        tick();
        SDR_ACK = 1'b0;
        n++;
        if (nDTACK === 1'b0) got = 1'b1;
      end
      check({tag, "_sdr_dtack_seen"}, got, 1);
      check({tag, "_sdr_latency"}, n, d + 1);
      finish_cycle(tag);
    end else begin
      pes = 0; got = 1'b0; last_pe = 1'b1;
      for (int k = 0; k < 128 && !got; k++) begin
        if (nDTACK === 1'b0) got = 1'b1;
        else begin
          pe = CLK_EN_68K_P;
          tick();
          last_pe = pe;
          if (pe) pes++;
        end
      end
      check({tag, "_dtack_seen"}, got, 1);
      check({tag, "_ws_penables"}, pes, exp_ws(a));
      check({tag, "_ws_on_penable"}, last_pe, 1);
      finish_cycle(tag);
    end
    check({tag, "_req_pulses"}, req_cnt - req0, (is_sdram(a) && !is_iack(a)) ? 1 : 0);
    check({tag, "_nberr"}, nBERR, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [23:0] a;
    int          req0, pes;
    bit          bad, got, pe, last_pe;

    #12;
    check("rst_dtack", nDTACK, 1);
    check("rst_berr", nBERR, 1);
    check("rst_req", SDR_REQ, 0);
    check("rst_rd", SDR_RD, 1);
    check("rst_busy", BUSY, 0);
    #1 nRESET = 1'b1;
    tick(); tick();

    run_cycle("wram_rd", 24'h100000, 1'b1, 0);
    run_cycle("io_wr", 24'h300000, 1'b0, 0);
    run_cycle("prom_rd", 24'h000400, 1'b1, 7);
    run_cycle("iack", 24'hFFFFFE, 1'b1, 0);
    run_cycle("sdr_same_clk", 24'hC00010, 1'b0, 0);

    // Abort during SDRAM wait: DRAIN ignores a new cycle until the ack arrives.
    req0 = req_cnt;
    start_cycle(24'h200100, 1'b1);
    check("drain_req", SDR_REQ, 1);
    tick(); tick();
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    tick();
    check("drain_no_dtack", nDTACK, 1);
    check("drain_busy", BUSY, 1);
    tick(); tick();
    a = 24'h100000;
    M68K_ADDR = a[23:1]; M68K_RW = 1'b1; nAS = 1'b0; nLDS = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (nDTACK !== 1'b1 || BUSY !== 1'b1) bad = 1'b1;
    end
    check("drain_ignores_new", bad, 0);
    SDR_ACK = 1'b1;
    tick();
    SDR_ACK = 1'b0;
    check("drain_done_idle", BUSY, 0);
    got = 1'b0; bad = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      pe = CLK_EN_68K_P;
      tick();
      if (pe) got = 1'b1;
      else if (nDTACK !== 1'b1) bad = 1'b1;
    end
    check("drain_wait_penable", bad, 0);
    check("drain_new_accepted", nDTACK, 0);
    finish_cycle("drain_new");
    check("drain_req_pulses", req_cnt - req0, 1);

    // TAS: strobes rise with nAS low, then the write half re-decodes.
    start_cycle(24'h100010, 1'b1);
    check("tas_rd_dtack", nDTACK, 0);
    tick();
    nUDS = 1'b1; nLDS = 1'b1;
    tick();
    check("tas_release", nDTACK, 1);
    check("tas_gap_idle", BUSY, 0);
    M68K_RW = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
    got = 1'b0; bad = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      pe = CLK_EN_68K_P;
      tick();
      if (pe) got = 1'b1;
      else if (nDTACK !== 1'b1) bad = 1'b1;
    end
    check("tas_wait_penable", bad, 0);
    check("tas_wr_dtack", nDTACK, 0);
    finish_cycle("tas_wr");

    // Randomized cycles across the whole map.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = 24'hFFFFF0 | 24'($urandom_range(0, 7) << 1);
      else a = {4'($urandom_range(0, 15)), 20'($urandom)};
      a[0] = 1'b0;
      run_cycle("rand", a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 9)));
    end

`ifdef DTACK_TIMEOUT_EN
    start_cycle(24'h000800, 1'b1);
    pes = 0; got = 1'b0; bad = 1'b0; last_pe = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      pe = CLK_EN_68K_P;
      tick();
      last_pe = pe;
      if (pe) pes++;
      if (nDTACK !== 1'b1) bad = 1'b1;
      if (nBERR === 1'b0) got = 1'b1;
    end
    check("to_berr_seen", got, 1);
    check("to_penables", pes, TIMEOUT_CYC);
    check("to_on_penable", last_pe, 1);
    check("to_no_dtack", bad, 0);
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    tick();
    check("to_berr_release", nBERR, 1);
    check("to_draining", BUSY, 1);
    tick(); tick();
    SDR_ACK = 1'b1;
    tick();
    SDR_ACK = 1'b0;
    check("to_drained", BUSY, 0);
    check("to_drain_dtack", nDTACK, 1);
    tick();
`endif

    // Asynchronous reset in the middle of an acknowledged cycle.
    start_cycle(24'h100000, 1'b1);
    check("rstmid_pre_dtack", nDTACK, 0);
    #2 nRESET = 1'b0;
    #1;
    check("rstmid_dtack", nDTACK, 1);
    check("rstmid_berr", nBERR, 1);
    check("rstmid_busy", BUSY, 0);
    check("rstmid_req", SDR_REQ, 0);
    check("rstmid_rd", SDR_RD, 1);
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    @(negedge CLK_48M);
    nRESET = 1'b1;
    tick(); tick();
    check("rstmid_after_busy", BUSY, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
